tbird_light_decoder: RTL and testbench

//  Receive-side monitor for the T-Bird tail-light sequencer: samples the 8-bit light bus
//  (left half [7:4], right half [3:0]) and recovers the switch code that produced it.

---
 rtl/tbird_pkg.sv | 25 ++
 rtl/tbird_light_decoder_if.sv | 11 +
 rtl/tbird_half_classify.sv | 20 ++
 rtl/tbird_light_decoder.sv | 79 +++++++
 tb/tb_tbird_light_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tbird_pkg.sv
// tbird_pkg: mode codes, half-step encoding helpers and FSM states for the light decoder
package tbird_pkg;
  typedef enum logic [2:0] {
    MODE_OFF         = 3'd0,
    MODE_RIGHT       = 3'd1,
    MODE_LEFT        = 3'd2,
    MODE_HAZARD      = 3'd3,
    MODE_BRAKE       = 3'd4,
    MODE_BRAKE_RIGHT = 3'd5,
    MODE_BRAKE_LEFT  = 3'd6
  } mode_t;
  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;
  typedef enum logic [1:0] {K_S0, K_ANIM, K_S4, K_ILL} kind_t;
  typedef enum logic {LEFT, RIGHT} dir_t;
  function automatic logic [3:0] step_nibble(input dir_t d, input logic [2:0] k);
    logic [4:0] ones;
    ones = (5'd1 << k) - 5'd1;
    return d == LEFT ? ones[3:0] : {ones[0], ones[1], ones[2], ones[3]};
  endfunction
  function automatic kind_t half_kind(input logic [2:0] p, input logic [2:0] c);
    return (p == 3'd0 && c == 3'd0) ? K_S0 :
           (p == 3'd4 && c == 3'd4) ? K_S4 :
           (c == (p == 3'd4 ? 3'd0 : p + 3'd1)) ? K_ANIM : K_ILL;
  endfunction
endpackage

// File: rtl/tbird_light_decoder_if.sv
// tbird_light_decoder_if: light-bus input and recovered-mode outputs of the decoder
interface tbird_light_decoder_if;
  logic       sample;
  logic [7:0] lights;
  logic [2:0] mode;
  logic       mode_valid;
  logic       pattern_error;
  logic [7:0] mode_changes;
  modport master (output sample, lights, input mode, mode_valid, pattern_error, mode_changes);
  modport slave (input sample, lights, output mode, mode_valid, pattern_error, mode_changes);
endinterface

// File: rtl/tbird_half_classify.sv
// tbird_half_classify: maps one light nibble to its animation step or flags it bad
module tbird_half_classify
  import tbird_pkg::*;
#(
  parameter dir_t DIR = LEFT
) (
  input  logic [3:0] nibble,
  output logic       bad,
  output logic [2:0] step
);
  always_comb begin
    bad = 1'b1;
    step = 3'd0;
    for (int k = 0; k < 5; k++)
      if (nibble == step_nibble(DIR, 3'(k))) begin
        bad = 1'b0;
        step = 3'(k);
      end
  end
endmodule

// File: rtl/tbird_light_decoder.sv
// tbird_light_decoder: recovers the T-Bird switch code from sampled light frames
module tbird_light_decoder
  import tbird_pkg::*;
#(
  parameter int LOCK_COUNT = 2
) (
  input logic clock,
  input logic reset_n,
  tbird_light_decoder_if.slave bus
);
  localparam logic [3:0] LOCK = 4'(LOCK_COUNT);
  logic       l_bad, r_bad, bad, legal, has_lock;
  logic [2:0] l_step, r_step, prev_l, prev_r;
  logic [3:0] cnt, next_cnt;
  kind_t      lk, rk;
  mode_t      pm, cand;
  state_t     state;
  tbird_half_classify #(.DIR(LEFT)) left_half (.nibble(bus.lights[7:4]), .bad(l_bad), .step(l_step));
  tbird_half_classify #(.DIR(RIGHT)) right_half (.nibble(bus.lights[3:0]), .bad(r_bad), .step(r_step));
  assign bad = l_bad | r_bad;
  assign lk = half_kind(prev_l, l_step);
  assign rk = half_kind(prev_r, r_step);
  assign next_cnt = (state == TRACK && cnt != 4'd0 && pm == cand) ? cnt + 4'd1 : 4'd1;
  always_comb begin
    legal = !bad && lk != K_ILL && rk != K_ILL;
    if (lk == K_ANIM) begin
      pm = rk == K_S0 ? MODE_LEFT : rk == K_S4 ? MODE_BRAKE_LEFT : MODE_HAZARD;
      legal = legal && (rk != K_ANIM || l_step == r_step);
    end else begin
      pm = rk == K_ANIM ? (lk == K_S0 ? MODE_RIGHT : MODE_BRAKE_RIGHT) : (lk == K_S0 ? MODE_OFF : MODE_BRAKE);
      legal = legal && (rk == K_ANIM || rk == lk);
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= SEEK;
      prev_l <= 3'd0;
      prev_r <= 3'd0;
      cand <= MODE_OFF;
      cnt <= 4'd0;
      has_lock <= 1'b0;
      bus.mode <= 3'd0;
      bus.mode_valid <= 1'b0;
      bus.pattern_error <= 1'b0;
      bus.mode_changes <= 8'd0;
    end else begin
      bus.pattern_error <= 1'b0;
      if (bus.sample) begin
        if (!bad) begin
          prev_l <= l_step;
          prev_r <= r_step;
        end
        if (state == SEEK) begin
          bus.pattern_error <= bad;
          if (!bad) state <= TRACK;
        end else if (!legal) begin
          bus.pattern_error <= 1'b1;
          bus.mode_valid <= 1'b0;
          cnt <= 4'd0;
          state <= bad ? SEEK : TRACK;
        end else if (!(state == LOCKED && pm == bus.mode)) begin
          cand <= pm;
          cnt <= next_cnt;
          if (next_cnt >= LOCK) begin
            bus.mode <= pm;
            bus.mode_valid <= 1'b1;
            has_lock <= 1'b1;
            state <= LOCKED;
            if (has_lock && pm != bus.mode && bus.mode_changes != 8'hFF)
              bus.mode_changes <= bus.mode_changes + 8'd1;
          end else begin
            bus.mode_valid <= 1'b0;
            state <= TRACK;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tbird_light_decoder.sv
// tb_tbird_light_decoder: scoreboard bench comparing the decoder against a behavioural model
module tb_tbird_light_decoder;
  localparam int LOCK = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [12:0] sb [$];
  logic [12:0] exp_v;
  int m_state, m_pl, m_pr, m_cand, m_cnt, m_mode, m_valid, m_err, m_has, m_changes;
  tbird_light_decoder_if bus ();
  tbird_light_decoder #(.LOCK_COUNT(LOCK)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [3:0] nib(input bit left, input int k);
    logic [3:0] t [5];
    if (left) t = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    else t = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF};
    return t[k];
  endfunction
  function automatic int step_of(input logic [3:0] n, input bit left);
    for (int k = 0; k < 5; k++) if (nib(left, k) == n) return k;
    return -1;
  endfunction
  function automatic int kind(input int p, input int c);
    if (p == 0 && c == 0) return 0;
    if (p == 4 && c == 4) return 2;
    if (c == (p + 1) % 5) return 1;
    return 3;
  endfunction
  function automatic int pair_mode(input int lk, input int rk, input int ls, input int rs);
    if (lk == 0 && rk == 0) return 0;
    if (lk == 0 && rk == 1) return 1;
    if (lk == 1 && rk == 0) return 2;
    if (lk == 1 && rk == 1) return ls == rs ? 3 : -1;
    if (lk == 2 && rk == 2) return 4;
    if (lk == 2 && rk == 1) return 5;
    if (lk == 1 && rk == 2) return 6;
    return -1;
  endfunction
  function automatic logic [12:0] obs();
    return {bus.mode, bus.mode_valid, bus.pattern_error, bus.mode_changes};
  endfunction
  task automatic model(input logic rn, input logic s, input logic [7:0] l);
    int ls, rs, md;
    bit bad;
    if (!rn) begin
      m_state = 0; m_pl = 0; m_pr = 0; m_cand = 0; m_cnt = 0;
      m_mode = 0; m_valid = 0; m_err = 0; m_has = 0; m_changes = 0;
      return;
    end
    m_err = 0;
    if (!s) return;
    ls = step_of(l[7:4], 1'b1);
    rs = step_of(l[3:0], 1'b0);
    bad = ls < 0 || rs < 0;
    if (m_state == 0) begin
      if (bad) m_err = 1;
      else begin m_pl = ls; m_pr = rs; m_state = 1; end
      return;
    end
    md = bad ? -1 : pair_mode(kind(m_pl, ls), kind(m_pr, rs), ls, rs);
    if (md < 0) begin
      m_err = 1; m_valid = 0; m_cnt = 0;
      if (bad) m_state = 0;
      else begin m_pl = ls; m_pr = rs; m_state = 1; end
      return;
    end
    m_pl = ls;
    m_pr = rs;
    if (m_state == 2 && md == m_mode) return;
    if (m_state == 1 && m_cnt > 0 && md == m_cand) m_cnt++;
    else begin m_cand = md; m_cnt = 1; end
    m_valid = 0;
    m_state = 1;
    if (m_cnt >= LOCK) begin
      if (m_has != 0 && md != m_mode && m_changes < 255) m_changes++;
      m_mode = md; m_valid = 1; m_has = 1; m_state = 2;
    end
  endtask
  task automatic drive(input logic rn, input logic s, input logic [7:0] l);
    @(negedge clock);
    reset_n = rn;
    bus.sample = s;
    bus.lights = l;
    model(rn, s, l);
    sb.push_back({3'(m_mode), 1'(m_valid), 1'(m_err), 8'(m_changes)});
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    logic [9:0] seq [4] = '{10'h000, 10'h300, 10'h300, 10'h300};
    drive(1'b0, 1'b1, 8'h00);
    exp_v = sb.pop_front();
    checks++;
    if (obs() !== 13'h0) begin errors++; $display("FAIL reset_state: got %h want %h", obs(), 13'h0); end
    foreach (seq[i]) begin
      drive(seq[i][9], seq[i][8], seq[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL reset_off step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd0, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL off_lock: got %h want %h", obs(), {3'd0, 1'b1, 1'b0, 8'd0}); end
  endtask
  task automatic test_right_turn();
    logic [9:0] seq [7] = '{10'h000, 10'h300, 10'h308, 10'h30C, 10'h30E, 10'h30F, 10'h300};
    foreach (seq[i]) begin
      drive(seq[i][9], seq[i][8], seq[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL right_turn step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd1, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL right_wrap: got %h want %h", obs(), {3'd1, 1'b1, 1'b0, 8'd0}); end
  endtask
  task automatic test_hazard();
    logic [9:0] a [10] = '{10'h000, 10'h300, 10'h318, 10'h33C, 10'h37E, 10'h3FF, 10'h300, 10'h318, 10'h33C, 10'h33E};
    logic [9:0] b [3] = '{10'h300, 10'h318, 10'h33C};
    foreach (a[i]) begin
      drive(a[i][9], a[i][8], a[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL hazard step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd3, 1'b0, 1'b1, 8'd0}) begin errors++; $display("FAIL hazard_corrupt: got %h want %h", obs(), {3'd3, 1'b0, 1'b1, 8'd0}); end
    foreach (b[i]) begin
      drive(b[i][9], b[i][8], b[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL hazard_relock step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd3, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL hazard_relock: got %h want %h", obs(), {3'd3, 1'b1, 1'b0, 8'd0}); end
  endtask
  task automatic test_brake_turn();
    logic [9:0] seq [7] = '{10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3F0, 10'h3F8, 10'h3FC};
    foreach (seq[i]) begin
      drive(seq[i][9], seq[i][8], seq[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL brake_turn step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd5, 1'b1, 1'b0, 8'd1}) begin errors++; $display("FAIL brake_change: got %h want %h", obs(), {3'd5, 1'b1, 1'b0, 8'd1}); end
  endtask
  task automatic test_bad_gap();
    logic [9:0] a [5] = '{10'h000, 10'h300, 10'h300, 10'h300, 10'h305};
    logic [9:0] b [6] = '{10'h2AA, 10'h255, 10'h2FF, 10'h300, 10'h300, 10'h300};
    foreach (a[i]) begin
      drive(a[i][9], a[i][8], a[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL bad_frame step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd0, 1'b0, 1'b1, 8'd0}) begin errors++; $display("FAIL bad_pulse: got %h want %h", obs(), {3'd0, 1'b0, 1'b1, 8'd0}); end
    foreach (b[i]) begin
      drive(b[i][9], b[i][8], b[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL gap_hold step %0d: got %h want %h", i, obs(), exp_v); end
      if (i == 2) begin
        checks++;
        if (obs() !== 13'h0) begin errors++; $display("FAIL gap_outputs: got %h want %h", obs(), 13'h0); end
      end
    end
  endtask
  task automatic test_reset_saturate();
    logic [9:0] a [5] = '{10'h000, 10'h300, 10'h300, 10'h300, 10'h108};
    logic [7:0] r [7] = '{8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h00, 8'h00, 8'h00};
    foreach (a[i]) begin
      drive(a[i][9], a[i][8], a[i][7:0]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL mid_reset step %0d: got %h want %h", i, obs(), exp_v); end
    end
    checks++;
    if (obs() !== 13'h0) begin errors++; $display("FAIL mid_reset: got %h want %h", obs(), 13'h0); end
    for (int n = 0; n < 3 + 150 * 7; n++) begin
      drive(1'b1, 1'b1, n < 3 ? 8'h00 : r[(n - 3) % 7]);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL saturate step %0d: got %h want %h", n, obs(), exp_v); end
    end
    checks++;
    if (obs() !== {3'd0, 1'b1, 1'b0, 8'd255}) begin errors++; $display("FAIL saturate_255: got %h want %h", obs(), {3'd0, 1'b1, 1'b0, 8'd255}); end
  endtask
  task automatic test_back_to_back();
    int md, t;
    logic [7:0] f;
    drive(1'b0, 1'b0, 8'h00);
    exp_v = sb.pop_front();
    md = 0;
    t = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 10 == 0) md = $urandom_range(0, 6);
      f[7:4] = (md == 2 || md == 3 || md == 6) ? nib(1'b1, t) : (md >= 4 ? 4'hF : 4'h0);
      f[3:0] = (md == 1 || md == 3 || md == 5) ? nib(1'b0, t) : (md >= 4 ? 4'hF : 4'h0);
      if ($urandom_range(0, 15) == 0) f = 8'($urandom);
      t = (t + 1) % 5;
      drive(1'b1, $urandom_range(0, 7) != 0, f);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL random step %0d: got %h want %h", n, obs(), exp_v); end
    end
  endtask
  initial begin
    bus.sample = 1'b0;
    bus.lights = 8'h00;
    test_reset();
    test_right_turn();
    test_hazard();
    test_brake_turn();
    test_bad_gap();
    test_reset_saturate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
